// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and defaults for the cache bus arbiter.
// Contents: arbiter FSM state enum, grant encoding, default address/data widths.
// No ports.
package arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_t;

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Sram-like request/response bundle (req/wr/size/addr/wdata -> rdata/addr_ok/data_ok).
// Ports: none; modport master = requester side, modport slave = responder side.
// Parameters ADDR_W/DATA_W default to the package widths.
interface cache_bus_arbiter_if #(
  parameter int ADDR_W = arb_pkg::ADDR_W,
  parameter int DATA_W = arb_pkg::DATA_W
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );

endinterface

// File: rtl/cache_bus_arbiter_pick.sv
// Combinational winner select between i-cache and d-cache requests.
// Ports: inst_req/data_req in, last_gnt in (only with ARB_ROUND_ROBIN_EN), gnt out.
// ARB_ROUND_ROBIN_EN defined: ties go to the side not granted last; undefined: data wins ties.
module arb_pick
  import arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  gnt_t last_gnt,
`endif
  output gnt_t gnt
);

  // gnt is only consumed when at least one request is present, so the
  // no-request value is arbitrary.
  always_comb begin
    gnt = GNT_DATA;
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_req && data_req) begin
      if (last_gnt == GNT_DATA) gnt = GNT_INST;
      else                      gnt = GNT_DATA;
    end else if (inst_req) begin
      gnt = GNT_INST;
    end
`else
    if (inst_req && !data_req) gnt = GNT_INST;
`endif
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Merges i-cache and d-cache sram-like ports onto one sram-like bus port, one transaction in flight.
// Ports: clk, rst (sync, active-high); cache_inst/cache_data (slave modports); mem (master modport).
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of data-first priority.
module cache_bus_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  cache_bus_arbiter_if.slave   cache_inst,
  cache_bus_arbiter_if.slave   cache_data,
  cache_bus_arbiter_if.master  mem
);

  import arb_pkg::*;

  arb_state_t        state, state_nxt;
  gnt_t              gnt, gnt_nxt, pick;
  logic              latch;
  logic              inst_addr_ok, inst_data_ok;
  logic              data_addr_ok, data_data_ok;
  logic              req_out;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  gnt_t last_gnt;

  always_ff @(posedge clk) begin
    if (rst)        last_gnt <= GNT_DATA;
    else if (latch) last_gnt <= pick;
  end
`endif

  arb_pick u_pick (
    .inst_req (cache_inst.req),
    .data_req (cache_data.req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_gnt (last_gnt),
`endif
    .gnt      (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      gnt     <= GNT_DATA;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      // Fields are captured once at grant; the master's later changes are ignored.
      if (latch) begin
        if (pick == GNT_DATA) begin
          wr_q    <= cache_data.wr;
          size_q  <= cache_data.size;
          addr_q  <= cache_data.addr;
          wdata_q <= cache_data.wdata;
        end else begin
          wr_q    <= cache_inst.wr;
          size_q  <= cache_inst.size;
          addr_q  <= cache_inst.addr;
          wdata_q <= cache_inst.wdata;
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    latch        = 1'b0;
    req_out      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (cache_inst.req || cache_data.req) begin
          latch     = 1'b1;
          gnt_nxt   = pick;
          state_nxt = ARB_REQ;
        end
      end
      ARB_REQ: begin
        req_out = 1'b1;
        if (mem.addr_ok) begin
          inst_addr_ok = (gnt == GNT_INST);
          data_addr_ok = (gnt == GNT_DATA);
          // A bridge may accept and finish in one cycle.
          if (mem.data_ok) begin
            inst_data_ok = (gnt == GNT_INST);
            data_data_ok = (gnt == GNT_DATA);
            state_nxt    = ARB_IDLE;
          end else begin
            state_nxt = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (mem.data_ok) begin
          inst_data_ok = (gnt == GNT_INST);
          data_data_ok = (gnt == GNT_DATA);
          state_nxt    = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign mem.req   = req_out;
  assign mem.wr    = wr_q;
  assign mem.size  = size_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  // Read data fans out unconditionally; data_ok alone qualifies it.
  assign cache_inst.rdata   = mem.rdata;
  assign cache_data.rdata   = mem.rdata;
  assign cache_inst.addr_ok = inst_addr_ok;
  assign cache_inst.data_ok = inst_data_ok;
  assign cache_data.addr_ok = data_addr_ok;
  assign cache_data.data_ok = data_data_ok;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed self-checking bench for cache_bus_arbiter.
// Ports: none; drives three sram-like interfaces and a 10 ns clock.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_cache_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_bus_arbiter_if inst_if ();
  cache_bus_arbiter_if data_if ();
  cache_bus_arbiter_if mem_if ();

  cache_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cache_inst (inst_if),
    .cache_data (data_if),
    .mem        (mem_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {inst addr_ok, inst data_ok, data addr_ok, data data_ok}
  function automatic logic [31:0] oks();
    return {28'd0, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok};
  endfunction

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    mem_if.addr_ok = aok;
    mem_if.data_ok = dok;
    mem_if.rdata   = rd;
  endtask

  logic [31:0] rr_addr [4];
  logic [31:0] rr_oks  [4];

  initial begin
    rst = 1'b1;
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wdata = 0;
    bus(0, 0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst mem_req",   {31'd0, mem_if.req}, 32'd0);
    check("rst mem_wr",    {31'd0, mem_if.wr},  32'd0);
    check("rst mem_size",  {30'd0, mem_if.size}, 32'd0);
    check("rst mem_addr",  mem_if.addr,  32'd0);
    check("rst mem_wdata", mem_if.wdata, 32'd0);
    check("rst oks",       oks(), 32'd0);

    // Lone inst read
    @(negedge clk);
    inst_if.req = 1; inst_if.addr = 32'hBFC0_0000; inst_if.size = 2'd2;
    #1 check("t1 idle req", {31'd0, mem_if.req}, 32'd0);
    @(negedge clk); #1;
    check("t1 req",  {31'd0, mem_if.req}, 32'd1);
    check("t1 addr", mem_if.addr, 32'hBFC0_0000);
    check("t1 oks before ack", oks(), 32'd0);
    @(negedge clk); bus(1, 0, 32'h0); #1;
    check("t1 addr_ok", oks(), 32'b1000);
    @(negedge clk); inst_if.req = 0; #1;     // addr_ok still high in WAIT: ignored
    check("t1 wait req", {31'd0, mem_if.req}, 32'd0);
    check("t1 wait addr_ok ignored", oks(), 32'd0);
    @(negedge clk); bus(0, 1, 32'h3C1D_A000); #1;
    check("t1 data_ok", oks(), 32'b0100);
    check("t1 rdata", inst_if.rdata, 32'h3C1D_A000);
    @(negedge clk); bus(0, 0, 32'h0); #1;
    check("t1 done req",   {31'd0, mem_if.req}, 32'd0);
    check("t1 held addr",  mem_if.addr, 32'hBFC0_0000);
    @(negedge clk); bus(0, 1, 32'h0); #1;   // stray data_ok in IDLE
    check("idle data_ok ignored", oks(), 32'd0);
    @(negedge clk); bus(0, 0, 32'h0); #1;
    check("idle stays idle", {31'd0, mem_if.req}, 32'd0);

    // Simultaneous requests; bus acks addr and data together
    @(negedge clk);
    inst_if.req = 1; inst_if.addr = 32'h0000_1000;
    data_if.req = 1; data_if.addr = 32'h8000_0040; data_if.size = 2'd2;
    #1 check("t2 idle req", {31'd0, mem_if.req}, 32'd0);
    @(negedge clk); #1;
    check("t2 first req",  {31'd0, mem_if.req}, 32'd1);
    check("t2 first addr", mem_if.addr, 32'h8000_0040);
    bus(1, 1, 32'h0); #1;
    check("t2 both oks data", oks(), 32'b0011);
    @(negedge clk); bus(0, 0, 32'h0); data_if.req = 0; #1;
    check("t2 back in idle", {31'd0, mem_if.req}, 32'd0);
    check("t2 idle oks", oks(), 32'd0);
    @(negedge clk); #1;
    check("t2 second req",  {31'd0, mem_if.req}, 32'd1);
    check("t2 second addr", mem_if.addr, 32'h0000_1000);
    bus(1, 1, 32'h0); #1;
    check("t2 both oks inst", oks(), 32'b1100);
    @(negedge clk); bus(0, 0, 32'h0); inst_if.req = 0; #1;
    check("t2 done", {31'd0, mem_if.req}, 32'd0);

    // Data write with a delayed addr_ok
    @(negedge clk);
    data_if.req = 1; data_if.wr = 1; data_if.size = 2'd2;
    data_if.addr = 32'h8000_0100; data_if.wdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    check("t4 req",   {31'd0, mem_if.req}, 32'd1);
    check("t4 wr",    {31'd0, mem_if.wr},  32'd1);
    check("t4 size",  {30'd0, mem_if.size}, 32'd2);
    check("t4 addr",  mem_if.addr,  32'h8000_0100);
    check("t4 wdata", mem_if.wdata, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check("t4 still req", {31'd0, mem_if.req}, 32'd1);
    check("t4 no ok yet", oks(), 32'd0);
    bus(1, 0, 32'h0); #1;
    check("t4 addr_ok", oks(), 32'b0010);
    @(negedge clk); bus(0, 0, 32'h0); data_if.req = 0; data_if.wr = 0; #1;
    check("t4 wait req", {31'd0, mem_if.req}, 32'd0);
    check("t4 held wr",  {31'd0, mem_if.wr},  32'd1);
    @(negedge clk); bus(0, 1, 32'h0); #1;
    check("t4 data_ok", oks(), 32'b0001);
    @(negedge clk); bus(0, 0, 32'h0);

    // Reset while waiting for data
    @(negedge clk); inst_if.req = 1; inst_if.addr = 32'h0000_2000;
    @(negedge clk); #1;
    check("t6 req", {31'd0, mem_if.req}, 32'd1);
    bus(1, 0, 32'h0);
    @(negedge clk); bus(0, 0, 32'h0); inst_if.req = 0; rst = 1; #1;
    check("t6 in wait", {31'd0, mem_if.req}, 32'd0);
    @(negedge clk); rst = 0; #1;
    check("t6 post-rst req",  {31'd0, mem_if.req}, 32'd0);
    check("t6 post-rst addr", mem_if.addr, 32'd0);
    check("t6 post-rst oks",  oks(), 32'd0);
    bus(0, 1, 32'h0); #1;
    check("t6 late data_ok dropped", oks(), 32'd0);
    @(negedge clk); bus(0, 0, 32'h0); #1;
    check("t6 idle", {31'd0, mem_if.req}, 32'd0);

    // Continuous ties straight after reset
`ifdef ARB_ROUND_ROBIN_EN
    rr_addr = '{32'h0000_1000, 32'h8000_0040, 32'h0000_1000, 32'h8000_0040};
    rr_oks  = '{32'b1100, 32'b0011, 32'b1100, 32'b0011};
`else
    rr_addr = '{32'h8000_0040, 32'h8000_0040, 32'h8000_0040, 32'h8000_0040};
    rr_oks  = '{32'b0011, 32'b0011, 32'b0011, 32'b0011};
`endif
    inst_if.addr = 32'h0000_1000; inst_if.wr = 0;
    data_if.addr = 32'h8000_0040; data_if.wr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus(0, 0, 32'h0); inst_if.req = 1; data_if.req = 1; #1;
      check($sformatf("tie%0d idle", i), {31'd0, mem_if.req}, 32'd0);
      @(negedge clk); #1;
      check($sformatf("tie%0d addr", i), mem_if.addr, rr_addr[i]);
      bus(1, 1, 32'h0); #1;
      check($sformatf("tie%0d oks", i), oks(), rr_oks[i]);
    end
    @(negedge clk);
    bus(0, 0, 32'h0); inst_if.req = 0; data_if.req = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
